// File: rtl/pll_rst_pkg.sv
// Shared types and sizing helpers for the PLL bring-up / staged reset sequencer.
package pll_rst_pkg;

    typedef enum logic [2:0] {
        S_PLLRST,
        S_WAITLK,
        S_FILT,
        S_REL,
        S_RUN,
        S_FAIL
    } state_t;

    localparam int RETRY_W = 4;

    // Width of the shared cycle counter: enough for the largest interval plus one spare bit.
    function automatic int cnt_w(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the CLK domain; clears on RST_X.
module sync_2ff (
    input  logic CLK,
    input  logic RST_X,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_rst_sequencer.sv
// PLL reset / lock qualification / ordered domain-reset release sequencer.
module pll_rst_sequencer
    import pll_rst_pkg::*;
#(
    parameter int NDOM       = 3,
    parameter int PLLRST_CYC = 16,
    parameter int LOCK_TO    = 65536,
    parameter int LOCK_FILT  = 256,
    parameter int DOM_GAP    = 128,
    parameter int MAX_RETRY  = 3
) (
    input  logic               CLK,
    input  logic               RST_X,
    input  logic               LOCKED,
    input  logic               SW_REQ,
    output logic               PLL_RST,
    output logic [NDOM-1:0]    RST_X_O,
    output logic               READY,
    output logic               FAIL,
    output logic [RETRY_W-1:0] RETRY_CNT
);

    localparam int                 CNT_W       = cnt_w(PLLRST_CYC, LOCK_TO, LOCK_FILT, DOM_GAP);
    localparam logic [CNT_W-1:0]   PLLRST_LAST = CNT_W'(PLLRST_CYC - 1);
    localparam logic [CNT_W-1:0]   LOCK_LAST   = CNT_W'(LOCK_TO - 1);
    localparam logic [CNT_W-1:0]   FILT_LAST   = CNT_W'(LOCK_FILT - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST    = CNT_W'(DOM_GAP - 1);
    localparam logic [3:0]         LAST_DOM    = 4'(NDOM - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);
    localparam logic [RETRY_W-1:0] RETRY_SAT   = {RETRY_W{1'b1}};

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [3:0]           dom_idx, dom_nxt;
    logic [RETRY_W-1:0]   retry, retry_nxt;
    logic                 lk_s;
    logic                 restart;
    logic                 pll_rst_nxt;
    logic [NDOM-1:0]      rst_x_o_nxt;
    logic                 ready_nxt;
    logic                 fail_nxt;

    sync_2ff u_lock_sync (
        .CLK   (CLK),
        .RST_X (RST_X),
        .d     (LOCKED),
        .q     (lk_s)
    );

    // State, counters and registered outputs; outputs are loaded from the decoded next state.
    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            state   <= S_PLLRST;
            cnt     <= '0;
            dom_idx <= '0;
            retry   <= '0;
            PLL_RST <= 1'b1;
            RST_X_O <= '0;
            READY   <= 1'b0;
            FAIL    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            dom_idx <= dom_nxt;
            retry   <= retry_nxt;
            PLL_RST <= pll_rst_nxt;
            RST_X_O <= rst_x_o_nxt;
            READY   <= ready_nxt;
            FAIL    <= fail_nxt;
        end
    end

    assign RETRY_CNT = retry;

    // Lock loss and software request share one restart path, so coincident events restart once.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        dom_nxt   = dom_idx;
        retry_nxt = retry;
        restart   = (state != S_FAIL) &&
                    (SW_REQ || (!lk_s && (state == S_REL || state == S_RUN)));

        if (restart) begin
            state_nxt = S_PLLRST;
            cnt_nxt   = '0;
            dom_nxt   = '0;
            retry_nxt = '0;
        end else begin
            case (state)
                S_PLLRST: begin
                    if (cnt == PLLRST_LAST) begin
                        state_nxt = S_WAITLK;
                        cnt_nxt   = '0;
                    end
                end
                S_WAITLK: begin
                    if (lk_s) begin
                        state_nxt = S_FILT;
                        cnt_nxt   = '0;
                    end else if (cnt == LOCK_LAST) begin
                        cnt_nxt = '0;
                        if (retry == RETRY_MAX) begin
                            state_nxt = S_FAIL;
                        end else begin
                            state_nxt = S_PLLRST;
                            retry_nxt = (retry == RETRY_SAT) ? retry : retry + 1'b1;
                        end
                    end
                end
                S_FILT: begin
                    if (!lk_s) begin
                        state_nxt = S_WAITLK;
                        cnt_nxt   = '0;
                    end else if (cnt == FILT_LAST) begin
                        cnt_nxt = '0;
                        dom_nxt = '0;
                        if (NDOM == 1) begin
                            state_nxt = S_RUN;
                            retry_nxt = '0;
                        end else begin
                            state_nxt = S_REL;
                        end
                    end
                end
                S_REL: begin
                    if (cnt == GAP_LAST) begin
                        cnt_nxt = '0;
                        dom_nxt = dom_idx + 4'd1;
                        if (dom_idx + 4'd1 == LAST_DOM) begin
                            state_nxt = S_RUN;
                            retry_nxt = '0;
                        end
                    end
                end
                S_RUN: begin
                    cnt_nxt = '0;
                end
                S_FAIL: begin
                    cnt_nxt = '0;
                end
                default: begin
                    state_nxt = S_PLLRST;
                    cnt_nxt   = '0;
                    dom_nxt   = '0;
                    retry_nxt = '0;
                end
            endcase
        end
    end

    // Domain i is released once the release index has reached it; everything is released in S_RUN.
    always_comb begin
        pll_rst_nxt = (state_nxt == S_PLLRST);
        ready_nxt   = (state_nxt == S_RUN);
        fail_nxt    = (state_nxt == S_FAIL);
        rst_x_o_nxt = '0;
        for (int i = 0; i < NDOM; i++) begin
            if (state_nxt == S_RUN || (state_nxt == S_REL && 4'(i) <= dom_nxt))
                rst_x_o_nxt[i] = 1'b1;
        end
    end

endmodule
